// File: rtl/airi5c_divider.sv
`default_nettype none
// ============================================================================
//  Module      : airi5c_divider
//  Description : Iterative radix-2 restoring divider for RV32M
//                DIV/DIVU/REM/REMU. One quotient bit per cycle, with
//                valid/ready request and response handshakes and an abort
//                input for pipeline flushes.
//  Revision    : 1.0 - initial release
// ============================================================================
module airi5c_divider #(
  parameter int XPR_LEN = 32
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  logic [1:0]         op_i,
  input  logic [XPR_LEN-1:0] dividend_i,
  input  logic [XPR_LEN-1:0] divisor_i,
  input  logic               kill_i,
  output logic               resp_valid_o,
  input  logic               resp_ready_i,
  output logic [XPR_LEN-1:0] resp_data_o
);

  localparam int CNT_W = $clog2(XPR_LEN) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_signed;
  logic               r_q_neg;
  logic               r_r_neg;
  logic               r_sel_rem;
  logic [CNT_W-1:0]   r_cnt;
  logic [XPR_LEN-1:0] r_quo;
  logic [XPR_LEN-1:0] r_rem;
  logic [XPR_LEN-1:0] r_dsr;
  logic [XPR_LEN-1:0] r_resp_data;

  logic               w_accept;
  logic               w_signed;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [XPR_LEN-1:0] w_a_mag;
  logic [XPR_LEN-1:0] w_b_mag;
  logic               w_div_zero;
  logic               w_ovf;
  logic [XPR_LEN:0]   w_trial;
  logic [XPR_LEN:0]   w_diff;
  logic               w_ge;
  logic [XPR_LEN-1:0] w_quo_fix;
  logic [XPR_LEN-1:0] w_rem_fix;

  // Operand decode at the accepting cycle; magnitudes only for signed ops.
  assign w_accept   = (r_state == S_IDLE) && req_valid_i && !kill_i;
  assign w_signed   = !op_i[0];
  assign w_a_neg    = w_signed && dividend_i[XPR_LEN-1];
  assign w_b_neg    = w_signed && divisor_i[XPR_LEN-1];
  assign w_a_mag    = w_a_neg ? (~dividend_i + 1'b1) : dividend_i;
  assign w_b_mag    = w_b_neg ? (~divisor_i + 1'b1) : divisor_i;
  assign w_div_zero = (divisor_i == '0);
  // Most-negative / -1 overflows in two's complement; the result is fixed.
  assign w_ovf      = w_signed && (dividend_i == {1'b1, {(XPR_LEN-1){1'b0}}}) && (&divisor_i);

  // Restoring step: shift {rem,quo} left, trial-subtract with one extra bit.
  assign w_trial    = {r_rem, r_quo[XPR_LEN-1]};
  assign w_diff     = w_trial - {1'b0, r_dsr};
  assign w_ge       = (w_trial >= {1'b0, r_dsr});

  // Sign correction applied once the magnitude result is complete.
  assign w_quo_fix  = (r_signed && r_q_neg) ? (~r_quo + 1'b1) : r_quo;
  assign w_rem_fix  = (r_signed && r_r_neg) ? (~r_rem + 1'b1) : r_rem;

  assign resp_data_o = r_resp_data;

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and handshake outputs; kill overrides every transition.
  always_comb begin
    w_state_nxt  = r_state;
    req_ready_o  = 1'b0;
    resp_valid_o = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready_o = 1'b1;
        if (w_accept) begin
          w_state_nxt = (w_div_zero || w_ovf) ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        if (r_cnt == CNT_W'(1)) begin
          w_state_nxt = S_FIX;
        end
      end
      S_FIX: begin
        w_state_nxt = S_DONE;
      end
      S_DONE: begin
        resp_valid_o = 1'b1;
        if (resp_ready_i) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (kill_i) begin
      w_state_nxt = S_IDLE;
    end
  end

  // Datapath: operand capture, iteration, sign fix and result register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_signed    <= 1'b0;
      r_q_neg     <= 1'b0;
      r_r_neg     <= 1'b0;
      r_sel_rem   <= 1'b0;
      r_cnt       <= '0;
      r_quo       <= '0;
      r_rem       <= '0;
      r_dsr       <= '0;
      r_resp_data <= '0;
    end else begin
      if (w_accept) begin
        r_signed  <= w_signed;
        r_q_neg   <= w_a_neg ^ w_b_neg;
        r_r_neg   <= w_a_neg;
        r_sel_rem <= op_i[1];
        r_cnt     <= CNT_W'(XPR_LEN);
        r_quo     <= w_a_mag;
        r_rem     <= '0;
        r_dsr     <= w_b_mag;
        if (w_div_zero) begin
          r_resp_data <= op_i[1] ? dividend_i : '1;
        end else if (w_ovf) begin
          r_resp_data <= op_i[1] ? '0 : {1'b1, {(XPR_LEN-1){1'b0}}};
        end
      end else if (r_state == S_CALC) begin
        r_cnt <= r_cnt - 1'b1;
        if (w_ge) begin
          r_rem <= w_diff[XPR_LEN-1:0];
          r_quo <= {r_quo[XPR_LEN-2:0], 1'b1};
        end else begin
          r_rem <= w_trial[XPR_LEN-1:0];
          r_quo <= {r_quo[XPR_LEN-2:0], 1'b0};
        end
      end else if ((r_state == S_FIX) && !kill_i) begin
        r_resp_data <= r_sel_rem ? w_rem_fix : w_quo_fix;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_airi5c_divider.sv
`default_nettype none
// ============================================================================
//  Module      : tb_airi5c_divider
//  Description : Directed self-checking bench for airi5c_divider.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_airi5c_divider;

  logic        clk_i;
  logic        rst_ni;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [1:0]  op_i;
  logic [31:0] dividend_i;
  logic [31:0] divisor_i;
  logic        kill_i;
  logic        resp_valid_o;
  logic        resp_ready_i;
  logic [31:0] resp_data_o;

  int checks;
  int errors;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  airi5c_divider #(.XPR_LEN(32)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .op_i         (op_i),
    .dividend_i   (dividend_i),
    .divisor_i    (divisor_i),
    .kill_i       (kill_i),
    .resp_valid_o (resp_valid_o),
    .resp_ready_i (resp_ready_i),
    .resp_data_o  (resp_data_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Present one request for one cycle; returns #1 after the accepting edge.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk_i);
    req_valid_i = 1'b1;
    op_i        = op;
    dividend_i  = a;
    divisor_i   = b;
    @(posedge clk_i);
    #1;
    req_valid_i = 1'b0;
    op_i        = 2'b01;
    dividend_i  = 32'hDEAD_BEEF;
    divisor_i   = 32'h0000_0001;
  endtask

  // Count edges (accepting edge = 1) until resp_valid_o, bounded.
  task automatic wait_resp(output int lat);
    lat = 1;
    while (!resp_valid_o && lat < 80) begin
      @(posedge clk_i);
      #1;
      lat++;
    end
  endtask

  task automatic consume();
    @(negedge clk_i);
    resp_ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    resp_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if (req_ready_o !== 1'b1) begin
      errors++; $display("FAIL reset_req_ready got %b want 1", req_ready_o);
    end
    checks++;
    if (resp_valid_o !== 1'b0) begin
      errors++; $display("FAIL reset_resp_valid got %b want 0", resp_valid_o);
    end
    checks++;
    if (resp_data_o !== 32'h0) begin
      errors++; $display("FAIL reset_resp_data got %h want 0", resp_data_o);
    end
  endtask

  // Normal-path operations: latency 34 edges, then handshake back to IDLE.
  task automatic test_normal_ops();
    logic [1:0]  ops [8];
    logic [31:0] as  [8];
    logic [31:0] bs  [8];
    logic [31:0] exp [8];
    int lat;
    ops[0] = OP_DIVU; as[0] = 32'd100;       bs[0] = 32'd7;          exp[0] = 32'd14;
    ops[1] = OP_REMU; as[1] = 32'd100;       bs[1] = 32'd7;          exp[1] = 32'd2;
    ops[2] = OP_DIV;  as[2] = 32'hFFFF_FFF9; bs[2] = 32'd2;          exp[2] = 32'hFFFF_FFFD;
    ops[3] = OP_REM;  as[3] = 32'hFFFF_FFF9; bs[3] = 32'd2;          exp[3] = 32'hFFFF_FFFF;
    ops[4] = OP_REM;  as[4] = 32'd7;         bs[4] = 32'hFFFF_FFFE;  exp[4] = 32'd1;
    ops[5] = OP_DIV;  as[5] = 32'hFFFF_FF9C; bs[5] = 32'hFFFF_FFF9;  exp[5] = 32'd14;
    ops[6] = OP_DIVU; as[6] = 32'hFFFF_FFFF; bs[6] = 32'd1;          exp[6] = 32'hFFFF_FFFF;
    ops[7] = OP_DIV;  as[7] = 32'h8000_0000; bs[7] = 32'd1;          exp[7] = 32'h8000_0000;
    for (int i = 0; i < 8; i++) begin
      issue(ops[i], as[i], bs[i]);
      wait_resp(lat);
      checks++;
      if (lat != 34) begin
        errors++; $display("FAIL normal_latency[%0d] got %0d want 34", i, lat);
      end
      checks++;
      if (resp_data_o !== exp[i]) begin
        errors++; $display("FAIL normal_data[%0d] got %h want %h", i, resp_data_o, exp[i]);
      end
      consume();
      checks++;
      if (req_ready_o !== 1'b1 || resp_valid_o !== 1'b0) begin
        errors++; $display("FAIL normal_release[%0d] got ready=%b valid=%b want 1/0",
                           i, req_ready_o, resp_valid_o);
      end
    end
  endtask

  // Divide-by-zero and signed overflow resolve at accept: 1-edge latency.
  task automatic test_special();
    logic [1:0]  ops [5];
    logic [31:0] as  [5];
    logic [31:0] bs  [5];
    logic [31:0] exp [5];
    int lat;
    ops[0] = OP_DIV;  as[0] = 32'd5;         bs[0] = 32'd0;         exp[0] = 32'hFFFF_FFFF;
    ops[1] = OP_REMU; as[1] = 32'd5;         bs[1] = 32'd0;         exp[1] = 32'd5;
    ops[2] = OP_DIV;  as[2] = 32'h8000_0000; bs[2] = 32'hFFFF_FFFF; exp[2] = 32'h8000_0000;
    ops[3] = OP_REM;  as[3] = 32'h8000_0000; bs[3] = 32'hFFFF_FFFF; exp[3] = 32'h0;
    ops[4] = OP_REM;  as[4] = 32'hFFFF_FFFB; bs[4] = 32'd0;         exp[4] = 32'hFFFF_FFFB;
    for (int i = 0; i < 5; i++) begin
      issue(ops[i], as[i], bs[i]);
      wait_resp(lat);
      checks++;
      if (lat != 1) begin
        errors++; $display("FAIL special_latency[%0d] got %0d want 1", i, lat);
      end
      checks++;
      if (resp_data_o !== exp[i]) begin
        errors++; $display("FAIL special_data[%0d] got %h want %h", i, resp_data_o, exp[i]);
      end
      consume();
    end
  endtask

  // Response held while the consumer stalls; a new request is refused.
  task automatic test_backpressure();
    int lat;
    int bad;
    issue(OP_DIVU, 32'd1000, 32'd10);
    wait_resp(lat);
    checks++;
    if (resp_valid_o !== 1'b1 || resp_data_o !== 32'd100) begin
      errors++; $display("FAIL hold_first got valid=%b data=%h want 1/00000064",
                         resp_valid_o, resp_data_o);
    end
    bad = 0;
    @(negedge clk_i);
    req_valid_i = 1'b1;
    op_i        = OP_DIVU;
    dividend_i  = 32'd77;
    divisor_i   = 32'd7;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk_i);
      #1;
      if (resp_valid_o !== 1'b1 || resp_data_o !== 32'd100 || req_ready_o !== 1'b0) bad++;
    end
    req_valid_i = 1'b0;
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL hold_stable got %0d bad cycles want 0", bad);
    end
    consume();
    checks++;
    if (req_ready_o !== 1'b1 || resp_valid_o !== 1'b0) begin
      errors++; $display("FAIL hold_release got ready=%b valid=%b want 1/0",
                         req_ready_o, resp_valid_o);
    end
  endtask

  // Abort mid-CALC, refused request under kill, then a clean operation.
  task automatic test_kill();
    int seen;
    int lat;
    issue(OP_DIVU, 32'd1000, 32'd3);
    repeat (9) begin
      @(posedge clk_i);
      #1;
    end
    @(negedge clk_i);
    kill_i = 1'b1;
    @(posedge clk_i);
    #1;
    kill_i = 1'b0;
    checks++;
    if (req_ready_o !== 1'b1 || resp_valid_o !== 1'b0) begin
      errors++; $display("FAIL kill_idle got ready=%b valid=%b want 1/0",
                         req_ready_o, resp_valid_o);
    end
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk_i);
      #1;
      if (resp_valid_o) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++; $display("FAIL kill_no_resp got %0d valid cycles want 0", seen);
    end
    @(negedge clk_i);
    req_valid_i = 1'b1;
    kill_i      = 1'b1;
    op_i        = OP_DIV;
    dividend_i  = 32'd5;
    divisor_i   = 32'd0;
    @(posedge clk_i);
    #1;
    req_valid_i = 1'b0;
    kill_i      = 1'b0;
    checks++;
    if (req_ready_o !== 1'b1 || resp_valid_o !== 1'b0) begin
      errors++; $display("FAIL kill_refuse got ready=%b valid=%b want 1/0",
                         req_ready_o, resp_valid_o);
    end
    issue(OP_DIVU, 32'd9, 32'd3);
    wait_resp(lat);
    checks++;
    if (lat != 34 || resp_data_o !== 32'd3) begin
      errors++; $display("FAIL kill_after got lat=%0d data=%h want 34/00000003",
                         lat, resp_data_o);
    end
    consume();
  endtask

  // Asynchronous reset during CALC clears outputs without a clock edge.
  task automatic test_reset_mid_calc();
    int lat;
    issue(OP_DIVU, 32'd500, 32'd4);
    repeat (5) begin
      @(posedge clk_i);
      #1;
    end
    #2;
    rst_ni = 1'b0;
    #1;
    checks++;
    if (req_ready_o !== 1'b1 || resp_valid_o !== 1'b0 || resp_data_o !== 32'h0) begin
      errors++; $display("FAIL rst_mid got ready=%b valid=%b data=%h want 1/0/0",
                         req_ready_o, resp_valid_o, resp_data_o);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    issue(OP_REMU, 32'd500, 32'd7);
    wait_resp(lat);
    checks++;
    if (lat != 34 || resp_data_o !== 32'd3) begin
      errors++; $display("FAIL rst_after got lat=%0d data=%h want 34/00000003",
                         lat, resp_data_o);
    end
    consume();
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    rst_ni       = 1'b0;
    req_valid_i  = 1'b0;
    op_i         = 2'b00;
    dividend_i   = 32'h0;
    divisor_i    = 32'h0;
    kill_i       = 1'b0;
    resp_ready_i = 1'b0;
    #12;
    test_reset();
    @(negedge clk_i);
    rst_ni = 1'b1;
    test_normal_ops();
    test_special();
    test_backpressure();
    test_kill();
    test_reset_mid_calc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
